// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port among an LCD reader (RD) and two writers (W0, W1).
// Handshake: a client holds req with addr/data stable until it sees a one-cycle done; oMem_Req/iMem_Done follow the same rule toward the controller.
module sdram_port_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 16,
  parameter int MAX_RD_RUN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              iRd_Req,
  input  logic [ADDR_W-1:0] iRd_Addr,
  output logic [DATA_W-1:0] oRd_Data,
  output logic              oRd_Done,
  input  logic              iW0_Req,
  input  logic [ADDR_W-1:0] iW0_Addr,
  input  logic [DATA_W-1:0] iW0_Data,
  output logic              oW0_Done,
  input  logic              iW1_Req,
  input  logic [ADDR_W-1:0] iW1_Addr,
  input  logic [DATA_W-1:0] iW1_Data,
  output logic              oW1_Done,
  output logic              oMem_Req,
  output logic              oMem_We,
  output logic [ADDR_W-1:0] oMem_Addr,
  output logic [DATA_W-1:0] oMem_Wr_Data,
  input  logic              iMem_Done,
  input  logic [DATA_W-1:0] iMem_Rd_Data,
  output logic [1:0]        oGrant
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_RD   = 2'd1;
  localparam logic [1:0] G_W0   = 2'd2;
  localparam logic [1:0] G_W1   = 2'd3;
  localparam logic [7:0] RUN_MAX = 8'(MAX_RD_RUN);

  state_t     state, state_d;
  logic       rr_w1;
  logic [7:0] rd_run;
  logic       w_pend;
  logic       any_req;
  logic       pick_rd;
  logic       pick_w0;
  logic [1:0] win;
  logic       start;
  logic       finish;

  always_comb begin
    w_pend  = iW0_Req | iW1_Req;
    any_req = iRd_Req | w_pend;
    // A full read run yields to a pending writer so the LCD refresh cannot starve drawing.
    pick_rd = iRd_Req && !((rd_run == RUN_MAX) && w_pend);
    pick_w0 = !pick_rd && iW0_Req && (!iW1_Req || !rr_w1);
    if (pick_rd)      win = G_RD;
    else if (pick_w0) win = G_W0;
    else              win = G_W1;
    start   = 1'b0;
    finish  = 1'b0;
    state_d = state;
    case (state)
      IDLE: begin
        if (en && any_req) begin
          start   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (iMem_Done) begin
          finish  = 1'b1;
          state_d = RELEASE;
        end
      end
      // The finishing client still holds req here, so nothing is sampled.
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oMem_Req     <= 1'b0;
      oMem_We      <= 1'b0;
      oMem_Addr    <= '0;
      oMem_Wr_Data <= '0;
      oGrant       <= G_NONE;
      oRd_Data     <= '0;
      oRd_Done     <= 1'b0;
      oW0_Done     <= 1'b0;
      oW1_Done     <= 1'b0;
      rr_w1        <= 1'b0;
      rd_run       <= '0;
    end else begin
      oRd_Done <= 1'b0;
      oW0_Done <= 1'b0;
      oW1_Done <= 1'b0;
      if (start) begin
        oMem_Req <= 1'b1;
        oGrant   <= win;
        case (win)
          G_RD: begin
            oMem_We      <= 1'b0;
            oMem_Addr    <= iRd_Addr;
            oMem_Wr_Data <= '0;
          end
          G_W0: begin
            oMem_We      <= 1'b1;
            oMem_Addr    <= iW0_Addr;
            oMem_Wr_Data <= iW0_Data;
          end
          default: begin
            oMem_We      <= 1'b1;
            oMem_Addr    <= iW1_Addr;
            oMem_Wr_Data <= iW1_Data;
          end
        endcase
        if (win == G_RD) begin
          if (!w_pend)                rd_run <= '0;
          else if (rd_run != RUN_MAX) rd_run <= rd_run + 8'd1;
        end else begin
          rd_run <= '0;
          rr_w1  <= (win == G_W0);
        end
      end else if (finish) begin
        oMem_Req     <= 1'b0;
        oMem_We      <= 1'b0;
        oMem_Addr    <= '0;
        oMem_Wr_Data <= '0;
        oGrant       <= G_NONE;
        oRd_Done     <= (oGrant == G_RD);
        oW0_Done     <= (oGrant == G_W0);
        oW1_Done     <= (oGrant == G_W1);
        if (oGrant == G_RD) oRd_Data <= iMem_Rd_Data;
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: random clients and controller against a transaction-level arbiter model.
module tb_sdram_port_arbiter;
  localparam int AW   = 24;
  localparam int DW   = 16;
  localparam int MAXR = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          iRd_Req, iW0_Req, iW1_Req;
  logic [AW-1:0] iRd_Addr, iW0_Addr, iW1_Addr;
  logic [DW-1:0] iW0_Data, iW1_Data;
  logic [DW-1:0] oRd_Data;
  logic          oRd_Done, oW0_Done, oW1_Done;
  logic          oMem_Req, oMem_We;
  logic [AW-1:0] oMem_Addr;
  logic [DW-1:0] oMem_Wr_Data;
  logic          iMem_Done;
  logic [DW-1:0] iMem_Rd_Data;
  logic [1:0]    oGrant;

  sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_RD_RUN(MAXR)) dut (
    .clk(clk), .rst(rst), .en(en),
    .iRd_Req(iRd_Req), .iRd_Addr(iRd_Addr), .oRd_Data(oRd_Data), .oRd_Done(oRd_Done),
    .iW0_Req(iW0_Req), .iW0_Addr(iW0_Addr), .iW0_Data(iW0_Data), .oW0_Done(oW0_Done),
    .iW1_Req(iW1_Req), .iW1_Addr(iW1_Addr), .iW1_Data(iW1_Data), .oW1_Done(oW1_Done),
    .oMem_Req(oMem_Req), .oMem_We(oMem_We), .oMem_Addr(oMem_Addr), .oMem_Wr_Data(oMem_Wr_Data),
    .iMem_Done(iMem_Done), .iMem_Rd_Data(iMem_Rd_Data), .oGrant(oGrant)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- client and controller drivers ----------------
  int            cl_left[3] = '{0, 0, 0};
  int            cl_gap[3]  = '{0, 0, 0};
  logic [AW-1:0] cl_addr[3];
  logic [DW-1:0] cl_data[3];
  bit            gap_mode = 1'b0;
  bit            spur_en  = 1'b0;
  int            ctl_lat  = -1;
  int            ctl_wait = 0;
  bit            ctl_armed = 1'b0;
  logic [DW-1:0] rd_exp_q[$];

  task automatic new_word(input int i);
    cl_addr[i] = AW'($urandom);
    cl_data[i] = DW'($urandom);
  endtask

  task automatic load(input int i, input int n);
    cl_left[i] = n;
    cl_gap[i]  = 0;
    new_word(i);
  endtask

  initial begin
    logic [2:0] dn;
    iRd_Req = 1'b0; iW0_Req = 1'b0; iW1_Req = 1'b0;
    iRd_Addr = '0; iW0_Addr = '0; iW1_Addr = '0; iW0_Data = '0; iW1_Data = '0;
    forever begin
      @(posedge clk); #1;
      dn = {oW1_Done, oW0_Done, oRd_Done};
      for (int i = 0; i < 3; i++) begin
        if (dn[i] && cl_left[i] > 0) begin
          if (i == 0) begin
            check("rd_sb_depth", 32'(rd_exp_q.size()), 32'd1);
            if (rd_exp_q.size() > 0) check("rd_sb_data", 32'(oRd_Data), 32'(rd_exp_q.pop_front()));
          end
          cl_left[i]--;
          new_word(i);
          if (gap_mode) cl_gap[i] = $urandom_range(0, 2);
        end else if (cl_gap[i] > 0) begin
          cl_gap[i]--;
        end
      end
      iRd_Req  = (cl_left[0] > 0) && (cl_gap[0] == 0);
      iW0_Req  = (cl_left[1] > 0) && (cl_gap[1] == 0);
      iW1_Req  = (cl_left[2] > 0) && (cl_gap[2] == 0);
      iRd_Addr = cl_addr[0];
      iW0_Addr = cl_addr[1];
      iW0_Data = cl_data[1];
      iW1_Addr = cl_addr[2];
      iW1_Data = cl_data[2];
    end
  end

  // Controller: answers each access after ctl_lat (or random) extra cycles; may emit stray dones when idle.
  initial begin
    iMem_Done = 1'b0;
    iMem_Rd_Data = '0;
    forever begin
      @(posedge clk); #1;
      iMem_Done = 1'b0;
      if (rst) begin
        ctl_armed = 1'b0;
      end else if (oMem_Req) begin
        if (!ctl_armed) begin
          ctl_armed = 1'b1;
          ctl_wait  = (ctl_lat >= 0) ? ctl_lat : int'($urandom_range(0, 5));
        end
        if (ctl_wait == 0) begin
          iMem_Done    = 1'b1;
          iMem_Rd_Data = DW'($urandom);
          if (oGrant == 2'd1) rd_exp_q.push_back(iMem_Rd_Data);
          ctl_wait = -1;
        end else if (ctl_wait > 0) begin
          ctl_wait--;
        end
      end else begin
        ctl_armed = 1'b0;
        if (spur_en && $urandom_range(0, 9) == 0) begin
          iMem_Done    = 1'b1;
          iMem_Rd_Data = DW'($urandom);
        end
      end
    end
  end

  // ---------------- reference model + compare ----------------
  // Owner codes match oGrant (1=RD, 2=W0, 3=W1); m_cool counts the dead cycle after a completion.
  int            m_owner, m_cool, m_run, m_rr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_rd_data;
  logic [2:0]    m_done;
  bit            m_wp;

  task automatic model_reset();
    m_owner = 0; m_cool = 0; m_run = 0; m_rr = 2;
    m_addr = '0; m_data = '0; m_rd_data = '0; m_done = '0;
  endtask

  task automatic model_next();
    m_done = '0;
    if (m_owner != 0) begin
      if (iMem_Done) begin
        m_done[m_owner-1] = 1'b1;
        if (m_owner == 1) m_rd_data = iMem_Rd_Data;
        m_owner = 0;
        m_cool  = 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (en && (iRd_Req || iW0_Req || iW1_Req)) begin
      m_wp = iW0_Req || iW1_Req;
      if (iRd_Req && !(m_wp && m_run >= MAXR)) begin
        m_owner = 1;
        m_addr  = iRd_Addr;
        m_run   = m_wp ? ((m_run < MAXR) ? m_run + 1 : MAXR) : 0;
      end else begin
        if (iW0_Req && iW1_Req) m_owner = m_rr;
        else                    m_owner = iW0_Req ? 2 : 3;
        m_addr = (m_owner == 2) ? iW0_Addr : iW1_Addr;
        m_data = (m_owner == 2) ? iW0_Data : iW1_Data;
        m_run  = 0;
        m_rr   = (m_owner == 2) ? 3 : 2;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) model_reset();
    check("mem_req", 32'(oMem_Req), 32'(m_owner != 0));
    check("grant", 32'(oGrant), 32'(m_owner));
    check("rd_done", 32'(oRd_Done), 32'(m_done[0]));
    check("w0_done", 32'(oW0_Done), 32'(m_done[1]));
    check("w1_done", 32'(oW1_Done), 32'(m_done[2]));
    check("rd_data", 32'(oRd_Data), 32'(m_rd_data));
    if (m_owner != 0) begin
      check("mem_addr", 32'(oMem_Addr), 32'(m_addr));
      check("mem_we", 32'(oMem_We), 32'(m_owner != 1));
      if (m_owner != 1) check("mem_wdata", 32'(oMem_Wr_Data), 32'(m_data));
    end
    if (!rst) model_next();
  end

  // ---------------- monitor ----------------
  int            cyc = 0;
  int            last_done = -1;
  bit            chk_gap = 1'b0;
  int            acc_cnt[4]  = '{0, 0, 0, 0};
  int            done_cnt[4] = '{0, 0, 0, 0};
  int            req_cycles = 0;
  logic          prev_req = 1'b0;
  logic [1:0]    g_log[$];
  logic [AW-1:0] rise_addr;
  logic [DW-1:0] rise_data;
  logic          rise_we;

  always @(negedge clk) begin
    cyc++;
    if (oMem_Req) req_cycles++;
    if (oMem_Req && !prev_req) begin
      g_log.push_back(oGrant);
      acc_cnt[oGrant]++;
      rise_addr = oMem_Addr;
      rise_data = oMem_Wr_Data;
      rise_we   = oMem_We;
      if (chk_gap && last_done >= 0) check("grant_gap", 32'(cyc - last_done), 32'd2);
    end
    if (oRd_Done) done_cnt[1]++;
    if (oW0_Done) done_cnt[2]++;
    if (oW1_Done) done_cnt[3]++;
    if (oRd_Done || oW0_Done || oW1_Done) last_done = cyc;
    prev_req = oMem_Req;
  end

  // ---------------- sequence helpers ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic drain(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    en = 1'b1;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = (cl_left[0] == 0) && (cl_left[1] == 0) && (cl_left[2] == 0) && !oMem_Req;
    end
    check(name, 32'(ok), 32'd1);
    repeat (3) tick();
  endtask

  task automatic wait_req(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = oMem_Req;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic pulse_reset();
    tick();
    rst = 1'b1;
    rd_exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // ---------------- main ----------------
  initial begin
    bit ok;
    int n;
    logic [1:0] exp_g;
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) tick();
    check("rst_mem_req", 32'(oMem_Req), 32'd0);
    check("rst_grant", 32'(oGrant), 32'd0);
    check("rst_rd_data", 32'(oRd_Data), 32'd0);
    check("rst_mem_addr", 32'(oMem_Addr), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Single W0 write, controller answers so req stays up 5 cycles.
    ctl_lat = 4;
    req_cycles = 0;
    done_cnt = '{0, 0, 0, 0};
    load(1, 1);
    cl_addr[1] = 24'd4809;
    cl_data[1] = 16'hFFE0;
    drain("w0_single_drain", 100);
    check("w0_req_cycles", 32'(req_cycles), 32'd5);
    check("w0_addr", 32'(rise_addr), 32'd4809);
    check("w0_data", 32'(rise_data), 32'hFFE0);
    check("w0_we", 32'(rise_we), 32'd1);
    check("w0_done_cnt", 32'(done_cnt[2]), 32'd1);
    check("w0_grant_idle", 32'(oGrant), 32'd0);

    // All three continuous from reset: RDx8, W0, RDx8, W1, RDx8, W0.
    pulse_reset();
    ctl_lat = -1;
    g_log.delete();
    load(0, 40); load(1, 3); load(2, 3);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      tick();
      ok = (g_log.size() >= 27);
    end
    check("seq_wait", 32'(ok), 32'd1);
    for (int k = 0; k < 27 && k < g_log.size(); k++) begin
      exp_g = (k % 9 != 8) ? 2'd1 : (((k / 9) % 2 == 0) ? 2'd2 : 2'd3);
      check("seq_grant", 32'(g_log[k]), 32'(exp_g));
    end
    drain("seq_drain", 3000);

    // W0/W1 continuous with RD idle: strict alternation, grant two cycles after each done pulse.
    g_log.delete();
    acc_cnt = '{0, 0, 0, 0};
    last_done = -1;
    chk_gap = 1'b1;
    load(1, 50); load(2, 50);
    drain("ww_drain", 3000);
    chk_gap = 1'b0;
    check("ww_w0_count", 32'(acc_cnt[2]), 32'd50);
    check("ww_w1_count", 32'(acc_cnt[3]), 32'd50);
    n = 0;
    for (int k = 1; k < g_log.size(); k++) if (g_log[k] == g_log[k-1]) n++;
    check("ww_alternate", 32'(n), 32'd0);

    // en dropped during BUSY.
    ctl_lat = 3;
    load(1, 1); load(2, 1);
    wait_req("en_wait_req", 50);
    en = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = oW0_Done || oW1_Done;
    end
    check("en_low_done", 32'(ok), 32'd1);
    n = g_log.size();
    repeat (10) tick();
    check("en_low_hold", 32'(g_log.size()), 32'(n));
    check("en_low_req", 32'(oMem_Req), 32'd0);
    drain("en_drain", 100);
    check("en_resume_cnt", 32'(g_log.size()), 32'(n + 1));
    if (g_log.size() == n + 1) check("en_resume_other", 32'(g_log[n]), 32'(5 - int'(g_log[n-1])));

    // Reset mid-access.
    ctl_lat = 4;
    load(0, 12); load(1, 3); load(2, 3);
    wait_req("rst_wait_req", 50);
    tick();
    rst = 1'b1;
    #1;
    check("rst_async_req", 32'(oMem_Req), 32'd0);
    check("rst_async_grant", 32'(oGrant), 32'd0);
    rd_exp_q.delete();
    repeat (2) tick();
    g_log.delete();
    rst = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      tick();
      ok = (g_log.size() >= 9);
    end
    check("rst_seq_wait", 32'(ok), 32'd1);
    if (g_log.size() >= 9) begin
      check("rst_first_rd", 32'(g_log[0]), 32'd1);
      check("rst_first_wr", 32'(g_log[8]), 32'd2);
    end
    drain("rst_drain", 2000);

    // Random traffic: gaps, random latency, stray controller dones, en toggling.
    ctl_lat  = -1;
    gap_mode = 1'b1;
    spur_en  = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      en = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < 3; i++)
        if (cl_left[i] == 0 && $urandom_range(0, 3) == 0) load(i, $urandom_range(1, 6));
    end
    spur_en = 1'b0;
    drain("rand_drain", 2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
